// File: rtl/inst_sequencer.sv
// inst_sequencer: fetches instructions from the PC, decodes the opcode and dispatches each to one execution unit.
// Define INST_SEQ_PERF_EN to add the busy/stall performance counters.
module inst_sequencer #(
    parameter int INST_BITS     = 128,
    parameter int OPCODE_BITS   = 4,
    parameter int N_UNITS       = 4,
    parameter int FETCH_TIMEOUT = 8,
    parameter int CNT_BITS      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic                 o_pc_flag,
    input  logic [INST_BITS-1:0] i_instruction,
    input  logic                 i_inst_valid,
    output logic [N_UNITS-1:0]   o_unit_start,
    output logic [INST_BITS-1:0] o_unit_inst,
    input  logic [N_UNITS-1:0]   i_unit_done,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_error,
    output logic [CNT_BITS-1:0]  o_inst_count
`ifdef INST_SEQ_PERF_EN
    ,
    output logic [31:0]          o_busy_cycles,
    output logic [31:0]          o_stall_cycles
`endif
);

    localparam int TMO_BITS = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_EXEC, S_HALT
    } state_t;

    state_t                 r_state, w_next;
    logic [INST_BITS-1:0]   r_unit_inst;
    logic [TMO_BITS-1:0]    r_tmo;
    logic [CNT_BITS-1:0]    r_count;
    logic                   r_error;
    logic [OPCODE_BITS-1:0] w_op;
    logic [N_UNITS-1:0]     w_sel;
    logic                   w_err_set, w_latch, w_retire;

    assign w_op = r_unit_inst[INST_BITS-1 -: OPCODE_BITS];

    // One-hot unit select straight from the latched opcode; all zero for NOP/HALT/illegal.
    for (genvar g = 0; g < N_UNITS; g++) begin : g_sel
        assign w_sel[g] = (w_op == OPCODE_BITS'(g + 1));
    end

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        w_latch   = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_FETCH;
            S_FETCH:  w_next = S_WAIT;
            S_WAIT: begin
                if (i_inst_valid) begin
                    w_latch = 1'b1;
                    w_next  = S_DECODE;
                end else if (r_tmo == TMO_BITS'(FETCH_TIMEOUT - 1)) begin
                    w_err_set = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_DECODE: begin
                if (w_op == '0) w_next = S_FETCH;
                else if (|w_sel) w_next = S_ISSUE;
                else begin
                    w_next    = S_HALT;
                    w_err_set = (w_op != '1);
                end
            end
            S_ISSUE:  w_next = S_EXEC;
            S_EXEC: begin
                if (|(i_unit_done & w_sel)) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_unit_inst <= '0;
            r_tmo       <= '0;
            r_count     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_unit_inst <= i_instruction;
            if (r_state == S_FETCH) r_tmo <= '0;
            else if (r_state == S_WAIT && !i_inst_valid) r_tmo <= r_tmo + 1'b1;
            if (w_err_set) r_error <= 1'b1;
            if (w_retire && r_count != '1) r_count <= r_count + 1'b1;
        end
    end

    assign o_pc_flag    = (r_state == S_FETCH);
    assign o_unit_start = (r_state == S_ISSUE) ? w_sel : '0;
    assign o_unit_inst  = r_unit_inst;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign o_halted     = (r_state == S_HALT);
    assign o_error      = r_error;
    assign o_inst_count = r_count;

`ifdef INST_SEQ_PERF_EN
    logic [31:0] r_busy_cycles, r_stall_cycles;

    // Both counters stop naturally in HALT since neither busy nor a stall state holds there.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy_cycles  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (o_busy && r_busy_cycles != '1) r_busy_cycles <= r_busy_cycles + 1'b1;
            if ((r_state == S_WAIT || r_state == S_EXEC) && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_busy_cycles  = r_busy_cycles;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Fetch/dispatch controller sitting between the program counter (instruction BRAM) and the execution units of the systolic array.
- Pulses the PC advance flag, captures each returned instruction, and decodes its opcode.
- Issues the instruction to exactly one unit and waits for that unit's done before fetching the next.
- Stops on a HALT opcode, an illegal opcode, or a fetch timeout.

Parameters:
- INST_BITS, 128, instruction width; must match the program counter.
- OPCODE_BITS, 4, opcode field = instruction[INST_BITS-1 -: OPCODE_BITS].
- N_UNITS, 4, number of execution units, 1..(2^OPCODE_BITS)-2.
- FETCH_TIMEOUT, 8, maximum cycles in WAIT_INST before the error is raised, >=2.
- CNT_BITS, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; sampled only in IDLE; begins program execution
- pc_flag  out  1  advance request to the program counter; one-cycle high pulse
- instruction  in  INST_BITS  instruction word from the program counter
- inst_valid  in  1  program counter's one-cycle init pulse; instruction is valid in that cycle
- unit_start  out  N_UNITS  one-hot, one-cycle start pulse per unit
- unit_inst  out  INST_BITS  latched instruction; stable from the ISSUE cycle until done is accepted
- unit_done  in  N_UNITS  per-unit completion; level or pulse
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- error  out  1  sticky; illegal opcode or fetch timeout
- inst_count  out  CNT_BITS  retired unit instructions; saturating

Behaviour:
- Reset values: state=IDLE; pc_flag, unit_start, busy, halted, error = 0; unit_inst, inst_count, timeout counter = 0.
- Reset asserted mid-operation aborts immediately. No unit_start is emitted after reset deasserts until a new start.
- Opcode map:
  - 0 = NOP.
  - 1..N_UNITS = dispatch to unit (opcode-1).
  - all-ones = HALT.
  - anything else = illegal.
- FSM transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: pc_flag=1 for this cycle only; clear timeout counter -> WAIT_INST.
  - WAIT_INST: pc_flag=0.
    - inst_valid=1: latch instruction into unit_inst -> DECODE.
    - Otherwise increment timeout counter. On reaching FETCH_TIMEOUT: error=1 -> HALT. This covers the PC's last address, where no init pulse is produced.
  - DECODE (one cycle, opcode taken from the latched word):
    - NOP -> FETCH.
    - unit op -> ISSUE.
    - HALT -> HALT.
    - illegal -> error=1, HALT.
  - ISSUE: unit_start[k]=1 for exactly one cycle -> EXEC.
  - EXEC: wait for unit_done[k]; other done bits are ignored.
    - On unit_done[k]=1: inst_count += 1, saturating at 2^CNT_BITS-1 -> FETCH.
  - HALT: halted=1. Remains until reset; start is ignored.
- pc_flag timing: pc_flag is never high in two consecutive cycles. The PC's rising-edge detector therefore sees every request.
- Latencies:
  - start accepted to first pc_flag: 1 cycle.
  - inst_valid to unit_start: 2 cycles (DECODE, ISSUE).
  - unit_done to next pc_flag: 1 cycle.
  - NOP round trip (pc_flag to next pc_flag) = 3 cycles plus PC latency.
- unit_done sampling: unit_done high in the ISSUE cycle is not sampled. unit_done is sampled in EXEC only, so the earliest accepted done is 1 cycle after unit_start.
- inst_valid seen outside WAIT_INST is ignored.

Optional Feature:
- Macro: INST_SEQ_PERF_EN.
- When defined:
  - Adds output busy_cycles[31:0]: counts every cycle with busy=1, saturating.
  - Adds output stall_cycles[31:0]: counts cycles spent in WAIT_INST or EXEC, saturating.
  - Both reset to 0, both frozen in HALT.
- When undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Program: op1, op2, HALT. Each unit asserts done 3 cycles after its start.
  - Required: unit_start = 0001 then 0010, each with unit_inst equal to the fetched word.
  - inst_count = 2, halted = 1, error = 0, exactly 3 pc_flag pulses.
- NOP, NOP, op1, HALT.
  - No unit_start for the NOPs; unit_start[0] once; inst_count = 1.
  - pc_flag pulses separated by at least 1 low cycle.
- Opcode 4'hE with N_UNITS=4.
  - error = 1, halted = 1, no unit_start, inst_count unchanged.
- inst_valid held low after pc_flag (PC at its last address).
  - After 8 cycles in WAIT_INST: error = 1, halted = 1.
- Reset pulsed during EXEC with unit_done never asserted.
  - All outputs return to reset values asynchronously.
  - Then start re-runs from IDLE.
- unit_done[1] asserted while waiting on unit 0; unit_done[0] asserted in the ISSUE cycle.
  - Neither is accepted.
  - FSM advances only on unit_done[0] sampled in EXEC.
